// File: rtl/react_run_length.sv
// react_run_length: run-length encoder for the one-bit reactive stream.
// Consecutive identical samples are grouped into (bit, length) tokens and
// queued in a small FIFO drained through a valid/ready handshake.
// Optional feature macro: REACT_RLE_FLUSH_EN adds a `flush` input that
// closes the run in progress on demand.
module react_run_length #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [0:0]                         __in0,
  input  logic                               in_en,
`ifdef REACT_RLE_FLUSH_EN
  input  logic                               flush,
`endif
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_bit,
  output logic [CNT_W-1:0]                   out_len,
  output logic                               ovf,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W-1:0] MAX_LEN = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               cur_bit;
  logic               cur_bit_nxt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic [1:0]         rst_pipe;
  logic               active;
  logic               sample;
  logic               flush_req;
  logic               push;
  logic               push_bit;
  logic [CNT_W-1:0]   push_len;
  logic               full;
  logic               pop;
  logic               do_push;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W:0]     mem [FIFO_DEPTH];
  logic [CNT_W:0]     head;

  // Two-stage release synchroniser; sampling starts only once it has filled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_pipe <= 2'b00;
    else      rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign active = rst_pipe[1];
  assign sample = active & in_en;

`ifdef REACT_RLE_FLUSH_EN
  assign flush_req = active & flush;
`else
  assign flush_req = 1'b0;
`endif

  // State register plus the run bookkeeping that travels with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cur_bit <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      cur_bit <= cur_bit_nxt;
      count   <= count_nxt;
    end
  end

  // Next-state: a sample opens a run; only a flush without a sample closes it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (sample) state_nxt = RUN;
      RUN:  if (flush_req && !sample) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Run update and token push decision for the current cycle
  always_comb begin
    push        = 1'b0;
    push_bit    = cur_bit;
    push_len    = count;
    cur_bit_nxt = cur_bit;
    count_nxt   = count;
    case (state)
      IDLE: begin
        if (sample) begin
          cur_bit_nxt = __in0[0];
          count_nxt   = CNT_W'(1);
        end
      end
      RUN: begin
        if (flush_req) begin
          push = 1'b1;
          if (sample) begin
            cur_bit_nxt = __in0[0];
            count_nxt   = CNT_W'(1);
          end else begin
            cur_bit_nxt = 1'b0;
            count_nxt   = '0;
          end
        end else if (sample) begin
          if (__in0[0] != cur_bit) begin
            push        = 1'b1;
            cur_bit_nxt = __in0[0];
            count_nxt   = CNT_W'(1);
          end else if (count == MAX_LEN) begin
            push      = 1'b1;
            count_nxt = CNT_W'(1);
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
      end
      default: begin
        cur_bit_nxt = 1'b0;
        count_nxt   = '0;
      end
    endcase
  end

  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign do_push   = push & (~full | pop);

  // Token storage; contents are qualified by level so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_bit, push_len};
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow: set when a token is lost to a full FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    ovf <= 1'b0;
    else if (push && full && !pop) ovf <= 1'b1;
  end

  assign head    = mem[rd_ptr];
  assign out_bit = out_valid ? head[CNT_W] : 1'b0;
  assign out_len = out_valid ? head[CNT_W-1:0] : '0;

endmodule

// File: tb/tb_react_run_length.sv
// tb_react_run_length: directed scoreboard bench for react_run_length.
// Stimulus pushes hand-computed tokens into a queue; a monitor pops and
// compares whenever the DUT hands a token over.
module tb_react_run_length;

  localparam int CNT_W      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic             b;
    logic [CNT_W-1:0] len;
  } tok_t;

  logic             clk;
  logic             rst;
  logic [0:0]       in0;
  logic             in_en;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic [CNT_W-1:0] out_len;
  logic             ovf;
  logic [LVL_W-1:0] level;
`ifdef REACT_RLE_FLUSH_EN
  logic             flush;
`endif

  tok_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  react_run_length #(.CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .__in0     (in0),
    .in_en     (in_en),
`ifdef REACT_RLE_FLUSH_EN
    .flush     (flush),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_len   (out_len),
    .ovf       (ovf),
    .level     (level)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every accepted token must match the head of the expected queue
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      tok_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL token_unexpected: got (%0d,%0d), required none", out_bit, out_len);
      end else begin
        e = exp_q.pop_front();
        if (out_bit === e.b && out_len === e.len) n_pass++;
        else $display("[TB] FAIL token: got (%0d,%0d), required (%0d,%0d)",
                      out_bit, out_len, e.b, e.len);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
  endtask

  task automatic expect_tok(input logic b, input int len);
    tok_t t;
    t.b   = b;
    t.len = CNT_W'(len);
    exp_q.push_back(t);
  endtask

  // Drive one sample (or idle cycle) and let one edge consume it
  task automatic apply_stimulus(input logic b, input logic en);
    in0[0] = b;
    in_en  = en;
    step();
    in_en  = 1'b0;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    in_en = 1'b0;
    in0   = 1'b0;
`ifdef REACT_RLE_FLUSH_EN
    flush = 1'b0;
`endif
    step();
    step();
    rst = 1'b1;
    repeat (3) step();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    step();
    step();
    check_output(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    $display("[TB] react_run_length bench start");
    out_ready = 1'b1;
    do_reset();
    check_output("reset_valid", out_valid, 0);
    check_output("reset_bit",   out_bit,   0);
    check_output("reset_len",   out_len,   0);
    check_output("reset_ovf",   ovf,       0);
    check_output("reset_level", level,     0);

    // Simple run of three ones closed by a zero
    expect_tok(1'b1, 3);
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    check_output("t1_valid_before", out_valid, 0);
    apply_stimulus(1'b0, 1'b1);
    check_output("t1_valid_after", out_valid, 1);
    step();
    check_output("t1_valid_popped", out_valid, 0);
    wait_drain("t1_drain");

    // Saturation at MAX splits a long run
    do_reset();
    expect_tok(1'b1, 255);
    expect_tok(1'b1, 45);
    for (int i = 0; i < 300; i++) apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    wait_drain("t2_drain");
    check_output("t2_ovf", ovf, 0);

    // Overflow with the consumer stalled, then ordered drain
    do_reset();
    out_ready = 1'b0;
    expect_tok(1'b0, 1);
    expect_tok(1'b1, 1);
    expect_tok(1'b0, 1);
    expect_tok(1'b1, 1);
    for (int i = 0; i < 7; i++) apply_stimulus(logic'(i % 2), 1'b1);
    check_output("t3_level_full", level, 4);
    check_output("t3_ovf_set", ovf, 1);
    check_output("t3_head_bit", out_bit, 0);
    check_output("t3_head_len", out_len, 1);
    step();
    step();
    check_output("t3_head_stable", out_len, 1);
    check_output("t3_valid_held", out_valid, 1);
    out_ready = 1'b1;
    wait_drain("t3_drain");
    check_output("t3_level_empty", level, 0);
    check_output("t3_ovf_sticky", ovf, 1);

    // Idle cycles between samples do not extend the run
    do_reset();
    expect_tok(1'b1, 2);
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    wait_drain("t4_drain");

    // Reset mid-run with tokens queued, then a sample right at release
    do_reset();
    out_ready = 1'b0;
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1);
    check_output("t5_level_queued", level, 2);
    rst = 1'b0;
    #1;
    check_output("t5_valid_rst", out_valid, 0);
    check_output("t5_level_rst", level, 0);
    check_output("t5_ovf_rst", ovf, 0);
    step();
    step();
    rst = 1'b1;
    apply_stimulus(1'b1, 1'b1);
    repeat (3) step();
    out_ready = 1'b1;
    expect_tok(1'b0, 1);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    wait_drain("t5_drain");

`ifdef REACT_RLE_FLUSH_EN
    // Flush closes the run; a flush while idle is ignored
    do_reset();
    out_ready = 1'b0;
    expect_tok(1'b0, 2);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    flush = 1'b1;
    step();
    check_output("t6_level_flush", level, 1);
    step();
    flush = 1'b0;
    check_output("t6_level_second", level, 1);
    out_ready = 1'b1;
    wait_drain("t6_drain");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
